reset_sequencer: RTL and testbench

//  Parametrised successor to the single-domain PLL-lock reset counter.
//  - Synchronises an asynchronous PLL-lock input.
//  - Requires lock to stay stable for a programmable hold time.
//  - Releases N reset domains one after another, staggered in time, so that

---
 rtl/reset_sequencer.sv | 177 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staggered multi-domain reset release from PLL lock; optional soft reset via RESET_SEQ_SOFT_RST_EN
module reset_sequencer #(
    parameter int N_DOMAINS      = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
`ifdef RESET_SEQ_SOFT_RST_EN
    parameter int DEBOUNCE_CYCLES = 1024,
`endif
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 locked_async,
`ifdef RESET_SEQ_SOFT_RST_EN
    input  logic                 soft_rst_req,
`endif
    output logic [N_DOMAINS-1:0] rst_out,
    output logic                 ready,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     lock_lost_cnt
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 cur, nxt;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   lock_s;
    logic                   soft_trig;
    logic [HW-1:0]          hold_cnt, hold_d;
    logic [SW-1:0]          stag_cnt, stag_d;
    logic [N_DOMAINS-1:0]   rst_d, rst_shift;
    logic                   ready_d;
    logic [CNT_W-1:0]       cnt_d;
    logic                   hold_done, stag_done;

    assign state     = cur;
    assign lock_s    = lock_sync[SYNC_STAGES-1];
    assign hold_done = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign stag_done = (stag_cnt == SW'(STAGGER_CYCLES - 1));
    // Released domains form a contiguous run of zeros from bit 0, so a left
    // shift clears exactly the next domain in order.
    assign rst_shift = rst_out << 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lock_sync <= '0;
        else       lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked_async};
    end

`ifdef RESET_SEQ_SOFT_RST_EN
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] soft_sync;
    logic                   soft_s;
    logic [DBW-1:0]         deb_cnt;
    logic                   armed;

    assign soft_s    = soft_sync[SYNC_STAGES-1];
    assign soft_trig = soft_s && armed && (deb_cnt == DBW'(DEBOUNCE_CYCLES - 1));

    // One trigger per press: disarmed after firing until the input is seen low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            soft_sync <= '0;
            deb_cnt   <= '0;
            armed     <= 1'b1;
        end else begin
            soft_sync <= {soft_sync[SYNC_STAGES-2:0], soft_rst_req};
            if (!soft_s) begin
                deb_cnt <= '0;
                armed   <= 1'b1;
            end else if (soft_trig) begin
                deb_cnt <= '0;
                armed   <= 1'b0;
            end else if (armed) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end
`else
    assign soft_trig = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= WAIT_LOCK;
        else       cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            WAIT_LOCK: if (lock_s) nxt = HOLD;
            HOLD: begin
                if (!lock_s)        nxt = WAIT_LOCK;
                else if (hold_done) nxt = (N_DOMAINS == 1) ? RUN : RELEASE;
            end
            RELEASE: begin
                if (!lock_s || soft_trig)             nxt = WAIT_LOCK;
                else if (stag_done && rst_shift == '0) nxt = RUN;
            end
            RUN:     if (!lock_s || soft_trig) nxt = WAIT_LOCK;
            default: nxt = WAIT_LOCK;
        endcase
    end

    always_comb begin
        rst_d   = rst_out;
        ready_d = ready;
        hold_d  = hold_cnt;
        stag_d  = stag_cnt;
        cnt_d   = lock_lost_cnt;
        case (cur)
            WAIT_LOCK: begin
                rst_d   = '1;
                ready_d = 1'b0;
                hold_d  = '0;
            end
            HOLD: begin
                if (!lock_s) begin
                    hold_d = '0;
                end else begin
                    hold_d = hold_cnt + 1'b1;
                    if (hold_done) begin
                        rst_d   = rst_shift;
                        ready_d = (N_DOMAINS == 1);
                        stag_d  = '0;
                    end
                end
            end
            RELEASE, RUN: begin
                // Lock loss takes priority over a coincident soft trigger.
                if (!lock_s) begin
                    rst_d   = '1;
                    ready_d = 1'b0;
                    if (lock_lost_cnt != '1) cnt_d = lock_lost_cnt + 1'b1;
                end else if (soft_trig) begin
                    rst_d   = '1;
                    ready_d = 1'b0;
                end else if (cur == RELEASE) begin
                    if (stag_done) begin
                        stag_d  = '0;
                        rst_d   = rst_shift;
                        ready_d = (rst_shift == '0);
                    end else begin
                        stag_d = stag_cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_out       <= '1;
            ready         <= 1'b0;
            hold_cnt      <= '0;
            stag_cnt      <= '0;
            lock_lost_cnt <= '0;
        end else begin
            rst_out       <= rst_d;
            ready         <= ready_d;
            hold_cnt      <= hold_d;
            stag_cnt      <= stag_d;
            lock_lost_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer (default, CNT_W=2 and N_DOMAINS=1 instances)
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic locked_async = 1'b0;
`ifdef RESET_SEQ_SOFT_RST_EN
    logic soft_rst_req = 1'b0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] rst_a, rst_b;
    logic [0:0] rst_c;
    logic       ready_a, ready_b, ready_c;
    logic [1:0] state_a, state_b, state_c;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;

    reset_sequencer #(
`ifdef RESET_SEQ_SOFT_RST_EN
        .DEBOUNCE_CYCLES(8),
`endif
        .CNT_W(8)
    ) dut_a (
        .clk(clk), .reset(reset), .locked_async(locked_async),
`ifdef RESET_SEQ_SOFT_RST_EN
        .soft_rst_req(soft_rst_req),
`endif
        .rst_out(rst_a), .ready(ready_a), .state(state_a), .lock_lost_cnt(cnt_a)
    );

    reset_sequencer #(
`ifdef RESET_SEQ_SOFT_RST_EN
        .DEBOUNCE_CYCLES(8),
`endif
        .CNT_W(2)
    ) dut_b (
        .clk(clk), .reset(reset), .locked_async(locked_async),
`ifdef RESET_SEQ_SOFT_RST_EN
        .soft_rst_req(soft_rst_req),
`endif
        .rst_out(rst_b), .ready(ready_b), .state(state_b), .lock_lost_cnt(cnt_b)
    );

    reset_sequencer #(
`ifdef RESET_SEQ_SOFT_RST_EN
        .DEBOUNCE_CYCLES(8),
`endif
        .N_DOMAINS(1),
        .CNT_W(8)
    ) dut_c (
        .clk(clk), .reset(reset), .locked_async(locked_async),
`ifdef RESET_SEQ_SOFT_RST_EN
        .soft_rst_req(soft_rst_req),
`endif
        .rst_out(rst_c), .ready(ready_c), .state(state_c), .lock_lost_cnt(cnt_c)
    );

    typedef struct {
        int         cyc;
        logic [2:0] rst;
        logic       rdy;
        logic [1:0] st;
        logic [7:0] cnt;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];
    ev_t q_c[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic push(input int id, input int c, input logic [2:0] r, input logic rd,
                        input logic [1:0] s, input logic [7:0] n);
        ev_t e;
        e.cyc = c; e.rst = r; e.rdy = rd; e.st = s; e.cnt = n;
        case (id)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    // Expected events of a lock-qualified release whose lock rise is sampled at edge e0.
    task automatic push_seq(input int e0, input int na, input int nb, input int nc, input bit full);
        push(0, e0 + 2,  3'b111, 1'b0, 2'd1, 8'(na));
        push(0, e0 + 18, 3'b110, 1'b0, 2'd2, 8'(na));
        push(1, e0 + 2,  3'b111, 1'b0, 2'd1, 8'(nb));
        push(1, e0 + 18, 3'b110, 1'b0, 2'd2, 8'(nb));
        if (full) begin
            push(0, e0 + 22, 3'b100, 1'b0, 2'd2, 8'(na));
            push(0, e0 + 26, 3'b000, 1'b1, 2'd3, 8'(na));
            push(1, e0 + 22, 3'b100, 1'b0, 2'd2, 8'(nb));
            push(1, e0 + 26, 3'b000, 1'b1, 2'd3, 8'(nb));
        end
        push(2, e0 + 2,  3'b001, 1'b0, 2'd1, 8'(nc));
        push(2, e0 + 18, 3'b000, 1'b1, 2'd3, 8'(nc));
    endtask

    task automatic check_ev(input int id, input ev_t got);
        ev_t   exp;
        bit    empty;
        string nm;
        empty = 1'b0;
        nm = (id == 0) ? "dut_a" : (id == 1) ? "dut_b" : "dut_c";
        case (id)
            0:       if (q_a.size() == 0) empty = 1'b1; else exp = q_a.pop_front();
            1:       if (q_b.size() == 0) empty = 1'b1; else exp = q_b.pop_front();
            default: if (q_c.size() == 0) empty = 1'b1; else exp = q_c.pop_front();
        endcase
        n_cmp++;
        if (empty) begin
            n_bad++;
            $display("FAIL %s unexpected_event: edge %0d rst=%b ready=%b state=%0d cnt=%0d, required no change",
                     nm, got.cyc, got.rst, got.rdy, got.st, got.cnt);
        end else if (got.cyc != exp.cyc || got.rst !== exp.rst || got.rdy !== exp.rdy ||
                     got.st !== exp.st || got.cnt !== exp.cnt) begin
            n_bad++;
            $display("FAIL %s event: got edge %0d rst=%b ready=%b state=%0d cnt=%0d, required edge %0d rst=%b ready=%b state=%0d cnt=%0d",
                     nm, got.cyc, got.rst, got.rdy, got.st, got.cnt,
                     exp.cyc, exp.rst, exp.rdy, exp.st, exp.cnt);
        end
    endtask

    function automatic bit differs(input ev_t a, input ev_t b);
        return (a.rst !== b.rst) || (a.rdy !== b.rdy) || (a.st !== b.st) || (a.cnt !== b.cnt);
    endfunction

    ev_t cur_a, prev_a, cur_b, prev_b, cur_c, prev_c;

    always @(negedge clk) begin
        cur_a.cyc = cyc; cur_a.rst = rst_a; cur_a.rdy = ready_a; cur_a.st = state_a; cur_a.cnt = cnt_a;
        if (reset) prev_a = cur_a;
        else if (differs(cur_a, prev_a)) begin check_ev(0, cur_a); prev_a = cur_a; end
    end

    always @(negedge clk) begin
        cur_b.cyc = cyc; cur_b.rst = rst_b; cur_b.rdy = ready_b; cur_b.st = state_b; cur_b.cnt = {6'b0, cnt_b};
        if (reset) prev_b = cur_b;
        else if (differs(cur_b, prev_b)) begin check_ev(1, cur_b); prev_b = cur_b; end
    end

    always @(negedge clk) begin
        cur_c.cyc = cyc; cur_c.rst = {2'b00, rst_c}; cur_c.rdy = ready_c; cur_c.st = state_c; cur_c.cnt = cnt_c;
        if (reset) prev_c = cur_c;
        else if (differs(cur_c, prev_c)) begin check_ev(2, cur_c); prev_c = cur_c; end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic chk_reset_all();
        chk("a_rst_out", 32'(rst_a), 32'h7);
        chk("a_ready",   32'(ready_a), 32'h0);
        chk("a_state",   32'(state_a), 32'h0);
        chk("a_cnt",     32'(cnt_a), 32'h0);
        chk("b_rst_out", 32'(rst_b), 32'h7);
        chk("b_cnt",     32'(cnt_b), 32'h0);
        chk("c_rst_out", 32'(rst_c), 32'h1);
        chk("c_ready",   32'(ready_c), 32'h0);
        chk("c_state",   32'(state_c), 32'h0);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int l;
        repeat (3) @(negedge clk);
        chk_reset_all();
        @(negedge clk);
        reset = 1'b0;

        // Lock glitch while in HOLD: back to WAIT_LOCK, not a counted loss.
        @(negedge clk);
        locked_async = 1'b1;
        e = cyc + 1;
        push(0, e + 2, 3'b111, 1'b0, 2'd1, 8'd0); push(0, e + 12, 3'b111, 1'b0, 2'd0, 8'd0);
        push(1, e + 2, 3'b111, 1'b0, 2'd1, 8'd0); push(1, e + 12, 3'b111, 1'b0, 2'd0, 8'd0);
        push(2, e + 2, 3'b001, 1'b0, 2'd1, 8'd0); push(2, e + 12, 3'b001, 1'b0, 2'd0, 8'd0);
        repeat (10) @(negedge clk);
        locked_async = 1'b0;
        wait_to(e + 20);

        @(negedge clk);
        locked_async = 1'b1;
        e = cyc + 1;
        push_seq(e, 0, 0, 0, 1'b1);
        wait_to(e + 30);

        // Repeated lock losses in RUN; dut_b saturates at 3.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            locked_async = 1'b0;
            l = cyc + 1;
            push(0, l + 2, 3'b111, 1'b0, 2'd0, 8'(i + 1));
            push(1, l + 2, 3'b111, 1'b0, 2'd0, 8'((i + 1 > 3) ? 3 : i + 1));
            push(2, l + 2, 3'b001, 1'b0, 2'd0, 8'(i + 1));
            wait_to(l + 4);
            @(negedge clk);
            locked_async = 1'b1;
            e = cyc + 1;
            push_seq(e, i + 1, (i + 1 > 3) ? 3 : i + 1, i + 1, 1'b1);
            wait_to(e + 30);
        end

        // Asynchronous reset in the middle of RELEASE.
        @(negedge clk);
        locked_async = 1'b0;
        l = cyc + 1;
        push(0, l + 2, 3'b111, 1'b0, 2'd0, 8'd6);
        push(1, l + 2, 3'b111, 1'b0, 2'd0, 8'd3);
        push(2, l + 2, 3'b001, 1'b0, 2'd0, 8'd6);
        wait_to(l + 4);
        @(negedge clk);
        locked_async = 1'b1;
        e = cyc + 1;
        push_seq(e, 6, 3, 6, 1'b0);
        wait_to(e + 19);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk_reset_all();
        locked_async = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

`ifdef RESET_SEQ_SOFT_RST_EN
        @(negedge clk);
        locked_async = 1'b1;
        e = cyc + 1;
        push_seq(e, 0, 0, 0, 1'b1);
        wait_to(e + 30);

        // Short press below the debounce length: no events expected.
        @(negedge clk);
        soft_rst_req = 1'b1;
        repeat (5) @(negedge clk);
        soft_rst_req = 1'b0;
        wait_to(cyc + 10);

        // Long press in RUN: one restart on the 8th synchronised high sample.
        @(negedge clk);
        soft_rst_req = 1'b1;
        l = cyc + 1;
        push(0, l + 9, 3'b111, 1'b0, 2'd0, 8'd0);
        push(1, l + 9, 3'b111, 1'b0, 2'd0, 8'd0);
        push(2, l + 9, 3'b001, 1'b0, 2'd0, 8'd0);
        push_seq(l + 8, 0, 0, 0, 1'b1);
        repeat (20) @(negedge clk);
        soft_rst_req = 1'b0;
        wait_to(l + 45);
`endif

        wait_to(cyc + 5);
        chk("a_pending_events", 32'(q_a.size()), 32'd0);
        chk("b_pending_events", 32'(q_b.size()), 32'd0);
        chk("c_pending_events", 32'(q_c.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
